poliriscv_imem_loader: RTL and testbench



---
 rtl/poliriscv_pkg.sv | 24 ++
 rtl/poliriscv_byte_packer.sv | 49 ++++
 rtl/poliriscv_imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_poliriscv_imem_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/poliriscv_pkg.sv
// ============================================================================
// Module   : poliriscv_pkg
// Purpose  : Shared loader state encoding and stream framing constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package poliriscv_pkg;

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    CKSUM  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } loader_state_e;

  localparam int LOADER_HDR_BYTES = 2;
  localparam int BYTES_PER_WORD   = 4;

endpackage

`default_nettype wire

// File: rtl/poliriscv_byte_packer.sv
// ============================================================================
// Module   : poliriscv_byte_packer
// Purpose  : Assembles little-endian bytes into 32-bit words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module poliriscv_byte_packer
  import poliriscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_i,
  input  logic        accept_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] C_LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q;
  logic [23:0] sr_q;

  // The 4th byte goes straight onto the output, so the word is ready on its accept edge.
  assign word_o       = {byte_i, sr_q};
  assign word_valid_o = accept_i && (idx_q == C_LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= 2'd0;
      sr_q  <= 24'd0;
    end else if (clear_i) begin
      idx_q <= 2'd0;
      sr_q  <= 24'd0;
    end else if (accept_i) begin
      idx_q <= idx_q + 2'd1;
      case (idx_q)
        2'd0:    sr_q[7:0]   <= byte_i;
        2'd1:    sr_q[15:8]  <= byte_i;
        2'd2:    sr_q[23:16] <= byte_i;
        default: sr_q        <= sr_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/poliriscv_imem_loader.sv
// ============================================================================
// Module   : poliriscv_imem_loader
// Purpose  : Boot loader filling instruction memory from a byte stream while
//            holding the core in reset. Optional checksum: POLIRISCV_LOADER_CKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module poliriscv_imem_loader
  import poliriscv_pkg::*;
#(
  parameter int INSTRUCTIONS = 256,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] C_MAX_WORDS = 16'(INSTRUCTIONS);

  generate
    if ((2 ** ADDR_W) < INSTRUCTIONS) begin : g_addr_check
      $error("ADDR_W too narrow for INSTRUCTIONS");
    end
  endgenerate

  loader_state_e     state_q;
  logic              in_ready_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              core_rst_q;
  logic              done_q;
  logic              err_q;
  logic [15:0]       cnt_q;
  logic [15:0]       word_idx_q;
`ifdef POLIRISCV_LOADER_CKSUM_EN
  logic [7:0]        xor_q;
`endif

  logic        accept;
  logic        pk_accept;
  logic        pk_clear;
  logic [31:0] pk_word;
  logic        pk_valid;
  logic [15:0] count_d;
  logic        count_bad_d;
  logic        last_word_d;

  assign accept      = in_valid && in_ready_q;
  assign pk_accept   = accept && (state_q == DATA);
  assign pk_clear    = (state_q != DATA);
  assign count_d     = {in_data, cnt_q[7:0]};
  assign count_bad_d = (count_d == 16'd0) || (count_d > C_MAX_WORDS);
  assign last_word_d = (word_idx_q == (cnt_q - 16'd1));

  poliriscv_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (in_data),
    .accept_i     (pk_accept),
    .clear_i      (pk_clear),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CNT_LO;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= 32'd0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 16'd0;
      word_idx_q <= 16'd0;
`ifdef POLIRISCV_LOADER_CKSUM_EN
      xor_q      <= 8'd0;
`endif
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        CNT_LO: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            cnt_q[7:0] <= in_data;
            state_q    <= CNT_HI;
          end
        end
        CNT_HI: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            cnt_q <= count_d;
            if (count_bad_d) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          in_ready_q <= 1'b1;
`ifdef POLIRISCV_LOADER_CKSUM_EN
          if (accept) xor_q <= xor_q ^ in_data;
`endif
          if (pk_valid) begin
            im_we_q    <= 1'b1;
            im_addr_q  <= word_idx_q[ADDR_W-1:0];
            im_wdata_q <= pk_word;
            word_idx_q <= word_idx_q + 16'd1;
            if (last_word_d) begin
`ifdef POLIRISCV_LOADER_CKSUM_EN
              state_q <= CKSUM;
`else
              // done/core_rst follow one cycle later so the final write lands first.
              state_q    <= DONE;
              in_ready_q <= 1'b0;
`endif
            end
          end
        end
        CKSUM: begin
`ifdef POLIRISCV_LOADER_CKSUM_EN
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            if (in_data == xor_q) begin
              state_q <= DONE;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
`else
          state_q    <= ERR;
          in_ready_q <= 1'b0;
          err_q      <= 1'b1;
`endif
        end
        DONE: begin
          in_ready_q <= 1'b0;
          done_q     <= 1'b1;
          core_rst_q <= 1'b0;
        end
        ERR: begin
          in_ready_q <= 1'b0;
          err_q      <= 1'b1;
          core_rst_q <= 1'b1;
        end
        default: begin
          state_q    <= ERR;
          in_ready_q <= 1'b0;
          err_q      <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_poliriscv_imem_loader.sv
// ============================================================================
// Module   : tb_poliriscv_imem_loader
// Purpose  : Scoreboard bench for the instruction-memory loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_poliriscv_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  poliriscv_imem_loader #(.INSTRUCTIONS(256), .ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst === 1'b1 && im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {24'd0, im_addr}, {24'd0, e.addr});
        chk("write_data", im_wdata, e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load2(input bit gaps, input logic [7:0] ck);
    logic [7:0] s [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    exp_q.push_back('{addr: 8'd0, data: 32'h00a00513});
    exp_q.push_back('{addr: 8'd1, data: 32'h00100593});
    for (int i = 0; i < 10; i++) send(s[i], gaps ? int'($urandom_range(1, 5)) : 0);
`ifdef POLIRISCV_LOADER_CKSUM_EN
    send(ck, gaps ? int'($urandom_range(1, 5)) : 0);
`else
    if (ck == 8'hff) $display("note: checksum byte unused in this build");
`endif
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    chk({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_done_not_yet"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_im_addr", {24'd0, im_addr}, 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'd0, in_ready}, 32'd1);

    // Plain two-word load.
    load2(1'b0, 8'h30);
    check_done("load2");
    chk("addr_held", {24'd0, im_addr}, 32'd1);

    // Extra bytes after done are ignored.
    in_data  = 8'hff;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_done_ready", {31'd0, in_ready}, 32'd0);
      chk("post_done_held", {30'd0, done, core_rst}, 32'd2);
    end
    in_valid = 1'b0;

    // Oversized count 257.
    do_reset();
    send(8'h01, 0);
    send(8'h01, 0);
    @(negedge clk);
    chk("cnt257_err", {31'd0, err}, 32'd1);
    chk("cnt257_core_rst", {31'd0, core_rst}, 32'd1);
    chk("cnt257_ready", {31'd0, in_ready}, 32'd0);
    in_data  = 8'h13;
    in_valid = 1'b1;
    repeat (8) @(negedge clk);
    chk("cnt257_err_held", {30'd0, err, done}, 32'd2);
    in_valid = 1'b0;

    // Zero count.
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge clk);
    chk("cnt0_err", {31'd0, err}, 32'd1);

    // Gapped stream with toggling valid.
    do_reset();
    load2(1'b1, 8'h30);
    check_done("gapped");

    // Reset after 5 data bytes, then single-word reload.
    do_reset();
    exp_q.push_back('{addr: 8'd0, data: 32'h00a00513});
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h05, 0); send(8'ha0, 0); send(8'h00, 0);
    send(8'h93, 0);
    @(negedge clk);
    do_reset();
    chk("midrst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("midrst_sb_empty", exp_q.size(), 32'd0);
    exp_q.push_back('{addr: 8'd0, data: 32'h00000013});
    send(8'h01, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
`ifdef POLIRISCV_LOADER_CKSUM_EN
    send(8'h13, 0);
`endif
    check_done("reload");

`ifdef POLIRISCV_LOADER_CKSUM_EN
    // Wrong checksum: both words still written, then error.
    do_reset();
    load2(1'b0, 8'h31);
    @(negedge clk);
    chk("badck_err", {31'd0, err}, 32'd1);
    chk("badck_core_rst", {31'd0, core_rst}, 32'd1);
    chk("badck_sb_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("badck_done", {31'd0, done}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("final_sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
